// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decides branch/jump outcome from comparator flags,
// checks the fetch prediction, issues a registered redirect on mispredict
// and maintains a 2-bit saturating branch history table plus event counters.

// One 2-bit saturating BHT counter; resets to weakly not-taken.
module bht_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr
);
  // Saturating up/down counter; inc and dec are never both set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ctr <= 2'b01;
    else if (inc && ctr != 2'b11)     ctr <= ctr + 2'b01;
    else if (dec && ctr != 2'b00)     ctr <= ctr - 2'b01;
  end
endmodule

module branch_resolve_unit #(
  parameter int BUS_WIDTH   = 64,
  parameter int BHT_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_is_branch,
  input  logic                 in_is_jal,
  input  logic                 in_is_jalr,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 neg,
  input  logic                 negu,
  input  logic [BUS_WIDTH-1:0] pc,
  input  logic [BUS_WIDTH-1:0] imm,
  input  logic [BUS_WIDTH-1:0] rs1,
  input  logic                 pred_taken,
  input  logic [BUS_WIDTH-1:0] pred_target,
  input  logic [BUS_WIDTH-1:0] lookup_pc,
  output logic                 lookup_taken,
  output logic                 redirect_valid,
  output logic [BUS_WIDTH-1:0] redirect_pc,
  output logic                 link_valid,
  output logic [BUS_WIDTH-1:0] link_data,
  output logic                 illegal_br,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t state, state_nx;

  logic                 is_jalr, is_jal, is_br, ctl;
  logic                 cond, f3_ok, taken, mispredict, accept;
  logic [BUS_WIDTH-1:0] br_target, jalr_sum, target, seq_pc, actual_next;
  logic [IDX-1:0]       upd_idx, lk_idx;

  logic                 redirect_nx, link_nx, illegal_nx, bht_upd;

  logic [BHT_ENTRIES-1:0][1:0] bht;

  // Kind decode with jalr > jal > branch priority.
  always_comb begin
    is_jalr = in_is_jalr;
    is_jal  = in_is_jal & ~in_is_jalr;
    is_br   = in_is_branch & ~in_is_jal & ~in_is_jalr;
    ctl     = in_is_branch | in_is_jal | in_is_jalr;
  end

  // Branch condition from comparator flags; 010/011 are reserved encodings.
  always_comb begin
    cond  = 1'b0;
    f3_ok = 1'b1;
    case (funct3)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = neg;
      3'b101:  cond = ~neg;
      3'b110:  cond = negu;
      3'b111:  cond = ~negu;
      default: f3_ok = 1'b0;
    endcase
  end

  // Target, resolved next PC and prediction check.
  always_comb begin
    br_target   = pc + imm;
    jalr_sum    = rs1 + imm;
    target      = is_jalr ? {jalr_sum[BUS_WIDTH-1:1], 1'b0} : br_target;
    seq_pc      = pc + BUS_WIDTH'(4);
    taken       = is_jalr | is_jal | (is_br & f3_ok & cond);
    actual_next = taken ? target : seq_pc;
    mispredict  = (taken != pred_taken) | (taken & (target != pred_target));
    accept      = in_valid & ctl & (state == RUN);
  end

  // FSM next state and next values of the registered pulse outputs.
  always_comb begin
    state_nx    = state;
    redirect_nx = 1'b0;
    link_nx     = 1'b0;
    illegal_nx  = 1'b0;
    bht_upd     = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          redirect_nx = mispredict;
          link_nx     = is_jal | is_jalr;
          illegal_nx  = is_br & ~f3_ok;
          bht_upd     = is_br & f3_ok;
          if (mispredict) state_nx = SQUASH;
        end
      end
      SQUASH: state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Registered outputs; PC/link data only load when their pulse fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_valid     <= 1'b0;
      link_data      <= '0;
      illegal_br     <= 1'b0;
    end else begin
      redirect_valid <= redirect_nx;
      link_valid     <= link_nx;
      illegal_br     <= illegal_nx;
      if (redirect_nx) redirect_pc <= actual_next;
      if (link_nx)     link_data   <= seq_pc;
    end
  end

  // Wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (accept)      branch_count     <= branch_count + 32'd1;
      if (redirect_nx) mispredict_count <= mispredict_count + 32'd1;
    end
  end

  assign upd_idx = pc[IDX+1:2];
  assign lk_idx  = lookup_pc[IDX+1:2];

  genvar e;
  generate
    for (e = 0; e < BHT_ENTRIES; e++) begin : g_bht
      logic hit;
      assign hit = bht_upd & (upd_idx == IDX'(e));
      bht_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit & taken),
        .dec   (hit & ~taken),
        .ctr   (bht[e])
      );
    end
  endgenerate

  // Prediction read returns the pre-update counter; no bypass.
  assign lookup_taken = bht[lk_idx][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int BW = 64;
  localparam int NE = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_is_branch, in_is_jal, in_is_jalr;
  logic [2:0] funct3;
  logic zero, neg, negu, pred_taken;
  logic [BW-1:0] pc, imm, rs1, pred_target, lookup_pc;
  logic lookup_taken, redirect_valid, link_valid, illegal_br;
  logic [BW-1:0] redirect_pc, link_data;
  logic [31:0] branch_count, mispredict_count;

  branch_resolve_unit #(.BUS_WIDTH(BW), .BHT_ENTRIES(NE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_is_branch(in_is_branch),
    .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr), .funct3(funct3),
    .zero(zero), .neg(neg), .negu(negu), .pc(pc), .imm(imm), .rs1(rs1),
    .pred_taken(pred_taken), .pred_target(pred_target), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .link_valid(link_valid), .link_data(link_data),
    .illegal_br(illegal_br), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, br, jal, jalr;
    logic [2:0] f3;
    logic z, n, nu, pt;
    logic [BW-1:0] pc, imm, rs1, ptg, lpc;
  } inst_t;

  typedef struct {
    logic rv, lv, ill;
    logic [BW-1:0] rpc, ld;
    logic [31:0] bc, mc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_err = 0;

  // reference model state
  int m_bht[NE];
  logic m_sq;
  logic [31:0] m_bc, m_mc;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_bht[i] = 1;
    m_sq = 1'b0; m_bc = '0; m_mc = '0;
  endtask

  // Expected response of one cycle's input, following the architectural rules.
  task automatic model_step(input inst_t t, output exp_t e);
    logic tk, ill, mis;
    logic [BW-1:0] tgt, nxt;
    int ix;
    e.rv = 0; e.lv = 0; e.ill = 0; e.rpc = '0; e.ld = '0;
    if (m_sq) m_sq = 1'b0;
    else if (t.valid && (t.br || t.jal || t.jalr)) begin
      ill = 0; tk = 1;
      if (t.jalr)     tgt = (t.rs1 + t.imm) & ~64'd1;
      else            tgt = t.pc + t.imm;
      if (!t.jalr && !t.jal) begin
        case (t.f3)
          3'd0: tk = t.z;   3'd1: tk = !t.z;
          3'd4: tk = t.n;   3'd5: tk = !t.n;
          3'd6: tk = t.nu;  3'd7: tk = !t.nu;
          default: begin tk = 0; ill = 1; end
        endcase
      end
      m_bc = m_bc + 1;
      nxt = tk ? tgt : t.pc + 64'd4;
      mis = (tk != t.pt) || (tk && tgt != t.ptg);
      if (mis) begin m_mc = m_mc + 1; e.rv = 1; e.rpc = nxt; m_sq = 1; end
      if (t.jal || t.jalr) begin e.lv = 1; e.ld = t.pc + 64'd4; end
      e.ill = ill;
      if (!t.jal && !t.jalr && !ill) begin
        ix = int'((t.pc >> 2) % NE);
        if (tk) m_bht[ix] = (m_bht[ix] < 3) ? m_bht[ix] + 1 : 3;
        else    m_bht[ix] = (m_bht[ix] > 0) ? m_bht[ix] - 1 : 0;
      end
    end
    e.bc = m_bc; e.mc = m_mc;
  endtask

  function automatic inst_t blank();
    inst_t t;
    t.valid = 0; t.br = 0; t.jal = 0; t.jalr = 0; t.f3 = 0;
    t.z = 0; t.n = 0; t.nu = 0; t.pt = 0;
    t.pc = 0; t.imm = 0; t.rs1 = 0; t.ptg = 0; t.lpc = 0;
    return t;
  endfunction

  task automatic drive(input inst_t t);
    exp_t e;
    logic lk;
    @(negedge clk);
    in_valid = t.valid; in_is_branch = t.br; in_is_jal = t.jal; in_is_jalr = t.jalr;
    funct3 = t.f3; zero = t.z; neg = t.n; negu = t.nu; pc = t.pc; imm = t.imm;
    rs1 = t.rs1; pred_taken = t.pt; pred_target = t.ptg; lookup_pc = t.lpc;
    #1;
    lk = (m_bht[int'((t.lpc >> 2) % NE)] >= 2);
    chk("lookup_taken", 64'(lookup_taken), 64'(lk));
    model_step(t, e);
    q.push_back(e);
  endtask

  // Monitor: every cycle with an outstanding expectation is checked.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
      if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
      chk("link_valid", 64'(link_valid), 64'(e.lv));
      if (e.lv) chk("link_data", link_data, e.ld);
      chk("illegal_br", 64'(illegal_br), 64'(e.ill));
      chk("branch_count", 64'(branch_count), 64'(e.bc));
      chk("mispredict_count", 64'(mispredict_count), 64'(e.mc));
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_redirect_valid"}, 64'(redirect_valid), 64'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
    chk({tag, "_link_valid"}, 64'(link_valid), 64'd0);
    chk({tag, "_link_data"}, link_data, 64'd0);
    chk({tag, "_illegal_br"}, 64'(illegal_br), 64'd0);
    chk({tag, "_branch_count"}, 64'(branch_count), 64'd0);
    chk({tag, "_mispredict_count"}, 64'(mispredict_count), 64'd0);
  endtask

  task automatic sweep_bht(input string tag);
    for (int i = 0; i < NE; i++) begin
      lookup_pc = 64'(i) << 2;
      #1;
      chk({tag, "_bht_lookup"}, 64'(lookup_taken), 64'd0);
    end
  endtask

  initial begin
    inst_t t;
    logic signed [11:0] s;
    int r;
    in_valid = 0; in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0; funct3 = 0;
    zero = 0; neg = 0; negu = 0; pc = 0; imm = 0; rs1 = 0; pred_taken = 0;
    pred_target = 0; lookup_pc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    sweep_bht("rst");
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken -> redirect, then a squashed BNE
    t = blank(); t.valid = 1; t.br = 1; t.f3 = 3'b000; t.z = 1;
    t.pc = 64'h100; t.imm = 64'h20; t.lpc = 64'h100;
    drive(t);
    t = blank(); t.valid = 1; t.br = 1; t.f3 = 3'b001; t.z = 0;
    t.pc = 64'h104; t.imm = 64'h40; t.lpc = 64'h104;
    drive(t);
    // BLTU not taken at 0x200 -> BHT[0] 01->00
    t = blank(); t.valid = 1; t.br = 1; t.f3 = 3'b110; t.nu = 0;
    t.pc = 64'h200; t.imm = 64'h8; t.lpc = 64'h200;
    drive(t);
    // JALR correctly predicted; link pc+4
    t = blank(); t.valid = 1; t.jalr = 1; t.rs1 = 64'h1003; t.imm = 64'h4;
    t.pc = 64'h40; t.pt = 1; t.ptg = 64'h1006; t.lpc = 64'h200;
    drive(t);
    // four taken BGE at 0x10 -> saturate, lookup sees pre-update value
    for (int k = 0; k < 5; k++) begin
      t = blank(); t.valid = (k < 4); t.br = 1; t.f3 = 3'b101; t.n = 0;
      t.pc = 64'h10; t.imm = 64'h40; t.pt = 1; t.ptg = 64'h50; t.lpc = 64'h10;
      drive(t);
    end
    // reserved funct3 -> illegal_br pulse, no redirect
    t = blank(); t.valid = 1; t.br = 1; t.f3 = 3'b010; t.pc = 64'h300; t.lpc = 64'h300;
    drive(t);
    t = blank(); drive(t);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      t = blank();
      t.valid = ($urandom_range(0, 99) < 85);
      r = $urandom_range(0, 9);
      if (r <= 5)      t.br = 1;
      else if (r == 6) t.jal = 1;
      else if (r == 7) t.jalr = 1;
      else if (r == 8) begin t.br = 1'($urandom); t.jal = 1'($urandom); t.jalr = 1'($urandom); end
      t.f3 = 3'($urandom); t.z = 1'($urandom); t.n = 1'($urandom); t.nu = 1'($urandom);
      t.pc = 64'h1000 + (64'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 9) == 0) t.pc = {$urandom, $urandom};
      s = 12'($urandom);
      t.imm = 64'(s);
      if ($urandom_range(0, 9) == 0) t.imm = {$urandom, $urandom};
      t.rs1 = {$urandom, $urandom};
      t.pt = 1'($urandom);
      if ($urandom_range(0, 1) == 0) t.ptg = t.jalr ? ((t.rs1 + t.imm) & ~64'd1) : t.pc + t.imm;
      else t.ptg = {$urandom, $urandom};
      t.lpc = 64'h1000 + (64'($urandom_range(0, 31)) << 2);
      drive(t);
    end
    t = blank(); drive(t);
    t = blank(); drive(t);

    // reset while SQUASH is active and redirect_valid is high
    t = blank(); t.valid = 1; t.jal = 1; t.pc = 64'h500; t.imm = 64'h80; t.pt = 0;
    t.lpc = 64'h500;
    drive(t);
    @(posedge clk);
    #3;
    chk("pre_reset_redirect_valid", 64'(redirect_valid), 64'd1);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    q.delete();
    model_reset();
    sweep_bht("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // first instruction after release: BEQ not taken, predicted taken -> redirect
    t = blank(); t.valid = 1; t.br = 1; t.f3 = 3'b000; t.z = 0; t.pc = 64'h600;
    t.imm = 64'h10; t.pt = 1; t.ptg = 64'h610; t.lpc = 64'h600;
    drive(t);
    t = blank(); drive(t);
    t = blank(); drive(t);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
